sync_fifo_v2: RTL and testbench
===============================

Name: sync_fifo_v2

Overview:
- Parametrised synchronous FIFO; next generation of the team's 16x8 FIFO.
- Generalised width and depth; depth need not be a power of two.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count output, and a first-word-fall-through (FWFT) read mode.
- Leaf buffering block between a producer and a consumer in one clock domain; checked by the existing UVM FIFO environment.

Parameters:
- FIFO_WIDTH, 16, data width in bits (>=1).
- FIFO_DEPTH, 8, number of entries (>=2, any integer).
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH (1..FIFO_DEPTH).
- AE_THRESH, 1, almostempty asserts when count <= AE_THRESH (0..FIFO_DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read/pop request.
- dout  out  FIFO_WIDTH  read data.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  count >= AF_THRESH.
- almostempty  out  1  count <= AE_THRESH.
- wr_ack  out  1  registered; write accepted last cycle.
- overflow  out  1  registered; write rejected last cycle.
- underflow  out  1  registered; read rejected last cycle.
- count  out  CNT_W  occupancy, where CNT_W = $clog2(FIFO_DEPTH+1).

Behaviour:
- Reset (rst=1 at a clock edge) forces wr_ptr=0, rd_ptr=0, count=0, dout=0, wr_ack=0, overflow=0, underflow=0.
- Memory contents are not reset.
- Reset wins over any simultaneous wr_en/rd_en; data in flight is discarded.
- Flags full, empty, almostfull, almostempty are combinational from count.
- Flags therefore update in the same cycle count changes.
- wr_ok = wr_en & (!full | rd_en).
- rd_ok = rd_en & !empty.
- Pointers wrap from FIFO_DEPTH-1 to 0 (explicit compare, no power-of-two assumption).
- On wr_ok: mem[wr_ptr] <= din; wr_ptr advances; wr_ack <= 1.
- On wr_en & !wr_ok: overflow <= 1, nothing stored.
- wr_ack and overflow are 0 whenever wr_en=0.
- On rd_en & empty: underflow <= 1, pointers unchanged, dout holds.
- Count rules:
  - +1 on wr_ok & !rd_ok.
  - -1 on rd_ok & !wr_ok.
  - unchanged if both or neither.
- Simultaneous rd_en & wr_en when full: both succeed, count stays FIFO_DEPTH, no overflow.
- Simultaneous rd_en & wr_en when empty: write only, underflow=1, count becomes 1.
- Standard mode (FWFT=0):
  - On rd_ok, dout <= mem[rd_ptr]; rd_ptr advances.
  - Read latency is 1 clock from rd_en to dout.
  - dout holds its value otherwise.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally and is valid whenever empty=0.
  - rd_en pops the head; the next entry appears in the same cycle rd_ptr updates.
  - A write to an empty FIFO is visible on dout the cycle after the write edge.
  - dout is don't-care while empty.
- Parameter legality is checked at elaboration; illegal combinations raise $error:
  - AF_THRESH outside 1..FIFO_DEPTH.
  - AE_THRESH >= AF_THRESH.
  - FIFO_DEPTH < 2.

Decomposition:
- Package fifo_v2_pkg holds:
  - default FIFO_WIDTH/FIFO_DEPTH.
  - function cnt_width(depth) returning $clog2(depth+1).
  - function ptr_width(depth).
  - enum fifo_mode_e {STD=0, FWFT=1}.
- The existing test-control counters stay in the verification package, not here.
- One sub-module, fifo_v2_mem:
  - FIFO_WIDTH x FIFO_DEPTH register array.
  - Synchronous write port; asynchronous read port addressed by rd_ptr.
  - The top level registers dout for standard mode.

Test Plan:
- Reset then 8 writes of 16'hA000..16'hA007 (DEPTH=8) -> wr_ack each cycle; count 1..8; almostfull at count 7; full at 8; empty deasserts after first write.
- Ninth write 16'hDEAD while full, rd_en=0 -> overflow=1 next cycle; count stays 8; later 8 reads return A000..A007 in order with 1-cycle latency.
- Read on empty after reset -> underflow=1 next cycle; dout stays 0; count 0; empty stays 1.
- Full FIFO with rd_en=wr_en=1 for 20 cycles (data 16'h0100+i) -> no overflow; count stays 8; pointer wrap exercised; drained sequence shows correct order across wrap.
- FWFT=1: write 16'h1234 to empty -> next cycle dout=16'h1234 with empty=0 and no rd_en; rd_en pop -> empty=1, count=0.
- Depth 5, AF_THRESH=4, AE_THRESH=2: fill and drain -> almostfull asserts at count 4, almostempty at count<=2; wrap at index 4->0 verified by a 12-entry stream.
- Assert rst mid-stream at count 5 with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, and the write is not stored.

Source files
------------

// File: rtl/fifo_v2_pkg.sv
// -----------------------------------------------------------------------------
// fifo_v2_pkg
// Shared definitions for the sync_fifo_v2 buffering block: default geometry,
// helpers that size the occupancy counter and the memory pointers, and the
// read-mode enumeration.
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_v2_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;

    // Read mode: registered read or first-word-fall-through.
    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // The occupancy counter has to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers address 0..depth-1; keep at least one bit for tiny depths.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_v2_mem.sv
// -----------------------------------------------------------------------------
// fifo_v2_mem
// FIFO_WIDTH x FIFO_DEPTH register array used as the FIFO storage.
// Ports:
//   clk_i    : clock, write on rising edge
//   we_i     : write enable
//   waddr_i  : write address (0..FIFO_DEPTH-1)
//   wdata_i  : write data
//   raddr_i  : read address (0..FIFO_DEPTH-1)
//   rdata_o  : read data, combinational from raddr_i
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module fifo_v2_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [FIFO_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [FIFO_WIDTH-1:0] rdata_o
);
    import fifo_v2_pkg::*;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read: lets the top either register it (standard mode)
    // or pass it straight through (first-word-fall-through).
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2
// Parametrised single-clock FIFO with arbitrary (non power-of-two) depth,
// programmable almost-full / almost-empty thresholds, occupancy output and
// selectable standard (registered) or first-word-fall-through read.
// Ports:
//   clk         : clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   din         : write data
//   wr_en       : write request
//   rd_en       : read / pop request
//   dout        : read data (registered in standard mode, head-of-queue in FWFT)
//   full        : count == FIFO_DEPTH
//   empty       : count == 0
//   almostfull  : count >= AF_THRESH
//   almostempty : count <= AE_THRESH
//   wr_ack      : registered, write accepted in the previous cycle
//   overflow    : registered, write rejected in the previous cycle
//   underflow   : registered, read rejected in the previous cycle
//   count       : current occupancy
// -----------------------------------------------------------------------------
module sync_fifo_v2 #(
    parameter  int FIFO_WIDTH = fifo_v2_pkg::DEF_FIFO_WIDTH,
    parameter  int FIFO_DEPTH = fifo_v2_pkg::DEF_FIFO_DEPTH,
    parameter  int AF_THRESH  = FIFO_DEPTH - 1,
    parameter  int AE_THRESH  = 1,
    parameter  int FWFT       = 0,
    localparam int CNT_W      = fifo_v2_pkg::cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_W-1:0]      count
);
    import fifo_v2_pkg::*;

    localparam int PTR_W = ptr_width(FIFO_DEPTH);

    localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_v2_pkg::FWFT : fifo_v2_pkg::STD;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_v2: FIFO_WIDTH must be >= 1 (got %0d)", FIFO_WIDTH);
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_v2: FIFO_DEPTH must be >= 2 (got %0d)", FIFO_DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
        $error("sync_fifo_v2: AF_THRESH %0d outside 1..%0d", AF_THRESH, FIFO_DEPTH);
    end
    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH) begin : g_bad_ae
        $error("sync_fifo_v2: AE_THRESH %0d must be >= 0 and < AF_THRESH %0d",
               AE_THRESH, AF_THRESH);
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
        $error("sync_fifo_v2: FWFT must be 0 or 1 (got %0d)", FWFT);
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  mem_we;
    logic [FIFO_WIDTH-1:0] rd_data;

    // Flags are decoded straight from the counter so they move in the same
    // cycle as count.
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CNT_AF);
    assign almostempty = (count_q <= CNT_AE);

    // A write while full is still accepted if a pop frees the slot in the
    // same cycle; a read while empty is never accepted.
    assign wr_ok = wr_en & (~full | rd_en);
    assign rd_ok = rd_en & ~empty;

    // Reset must win over a simultaneous write, including the array.
    assign mem_we = wr_ok & ~rst;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    fifo_v2_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        wr_ack_d    = wr_ok;
        overflow_d  = wr_en & ~wr_ok;
        underflow_d = rd_en & empty;

        // Explicit wrap compare: depth need not be a power of two.
        if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            dout_d   = rd_data;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // In FWFT mode the head entry is presented directly; it only means
    // something while empty is low.
    assign dout      = (MODE == fifo_v2_pkg::FWFT) ? rd_data : dout_q;
    assign count     = count_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_v2
// Drives three FIFO configurations from one shared stimulus stream:
//   0: depth 8, standard read, AF=7, AE=1
//   1: depth 8, first-word-fall-through, AF=7, AE=1
//   2: depth 5, standard read, AF=4, AE=2
// Each is compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_v2;

    typedef logic [15:0] word_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  wr_en;
    logic  rd_en;
    word_t din;

    always #5 clk = ~clk;

    word_t      dout0, dout1, dout2;
    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic       full0, empty0, af0, ae0, wa0, ov0, uf0;
    logic       full1, empty1, af1, ae1, wa1, ov1, uf1;
    logic       full2, empty2, af2, ae2, wa2, ov2, uf2;

    sync_fifo_v2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout0),
        .full(full0), .empty(empty0), .almostfull(af0), .almostempty(ae0),
        .wr_ack(wa0), .overflow(ov0), .underflow(uf0), .count(cnt0)
    );

    sync_fifo_v2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout1),
        .full(full1), .empty(empty1), .almostfull(af1), .almostempty(ae1),
        .wr_ack(wa1), .overflow(ov1), .underflow(uf1), .count(cnt1)
    );

    sync_fifo_v2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(2), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout2),
        .full(full2), .empty(empty2), .almostfull(af2), .almostempty(ae2),
        .wr_ack(wa2), .overflow(ov2), .underflow(uf2), .count(cnt2)
    );

    // Reference model state, one slot per configuration.
    int    mdepth [3] = '{8, 8, 5};
    int    maf    [3] = '{7, 7, 4};
    int    mae    [3] = '{1, 1, 2};
    bit    mfwft  [3] = '{1'b0, 1'b1, 1'b0};
    string mname  [3] = '{"std8", "fwft8", "std5"};
    word_t mq     [3][$];
    word_t mdout  [3];
    bit    mwa    [3];
    bit    mov    [3];
    bit    muf    [3];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of FIFO behaviour expressed as queue operations.
    task automatic model_edge(input int k);
        int  n;
        bit  wok, rok;
        word_t head;
        if (rst) begin
            mq[k].delete();
            mdout[k] = '0;
            mwa[k]   = 1'b0;
            mov[k]   = 1'b0;
            muf[k]   = 1'b0;
        end else begin
            n   = mq[k].size();
            wok = wr_en && ((n != mdepth[k]) || rd_en);
            rok = rd_en && (n != 0);
            if (rok) begin
                head = mq[k].pop_front();
                if (!mfwft[k]) mdout[k] = head;
            end
            if (wok) mq[k].push_back(din);
            mwa[k] = wok;
            mov[k] = wr_en && !wok;
            muf[k] = rd_en && (n == 0);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [3:0] cnt, input logic f, input logic e,
                            input logic af, input logic ae, input logic wa, input logic ov,
                            input logic uf, input word_t dq);
        int n;
        n = mq[k].size();
        chk({mname[k], ".count"},       {28'd0, cnt}, n);
        chk({mname[k], ".full"},        f,  n == mdepth[k]);
        chk({mname[k], ".empty"},       e,  n == 0);
        chk({mname[k], ".almostfull"},  af, n >= maf[k]);
        chk({mname[k], ".almostempty"}, ae, n <= mae[k]);
        chk({mname[k], ".wr_ack"},      wa, mwa[k]);
        chk({mname[k], ".overflow"},    ov, mov[k]);
        chk({mname[k], ".underflow"},   uf, muf[k]);
        if (!mfwft[k]) begin
            chk({mname[k], ".dout"}, dq, mdout[k]);
        end else if (n > 0) begin
            chk({mname[k], ".dout"}, dq, mq[k][0]);
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input word_t d);
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        cmp_inst(0, cnt0, full0, empty0, af0, ae0, wa0, ov0, uf0, dout0);
        cmp_inst(1, cnt1, full1, empty1, af1, ae1, wa1, ov1, uf1, dout1);
        cmp_inst(2, {1'b0, cnt2}, full2, empty2, af2, ae2, wa2, ov2, uf2, dout2);
    endtask

    initial begin
        int wbias, rbias;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        // Reset state
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);

        // Read on empty: underflow, dout holds 0
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // Simultaneous read and write on empty: write only, underflow
        step(0, 1, 1, 16'h3333);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 8; i++) step(0, 1, 0, 16'hA000 + 16'(i));
        step(0, 1, 0, 16'hDEAD);
        step(0, 0, 0, 16'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // Full with concurrent read/write for 20 cycles, then drain across wrap
        for (int i = 0; i < 8; i++) step(0, 1, 0, 16'h0200 + 16'(i));
        for (int i = 0; i < 20; i++) step(0, 1, 1, 16'h0100 + 16'(i));
        for (int i = 0; i < 9; i++) step(0, 0, 1, 16'h0);

        // Single word: FWFT shows it without rd_en, then pop
        step(0, 1, 0, 16'h1234);
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // 12-entry stream exercising wrap of the depth-5 instance
        step(0, 1, 0, 16'h5000);
        step(0, 1, 0, 16'h5001);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 16'h5002 + 16'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0);

        // Reset mid-stream at count 5 with a write pending
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h7000 + 16'(i));
        step(1, 1, 0, 16'hBEEF);
        step(0, 0, 1, 16'h0);
        step(0, 1, 0, 16'h7777);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);

        // Randomised traffic with phase-varying bias and rare resets
        wbias = 50;
        rbias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                wbias = $urandom_range(10, 90);
                rbias = $urandom_range(10, 90);
            end
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 99) < wbias,
                 $urandom_range(0, 99) < rbias,
                 word_t'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
